// File: rtl/systolic_a_skew_feeder_if.sv
// Stream-side and array-side bundle of the systolic activation skew feeder.
// The master drives the activation stream; the slave (the feeder) drives the array rows.
interface systolic_a_skew_feeder_if #(
    parameter int ROW_NUM          = 16,
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CNT_WIDTH        = 16
);
    logic                                  s_valid;
    logic                                  s_ready;
    logic [ROW_NUM*INPUT_DATA_WIDTH-1:0]   s_data;
    logic                                  s_last;
    logic [ROW_NUM*INPUT_DATA_WIDTH-1:0]   a_bus;
    logic [ROW_NUM-1:0]                    en_bus;
    logic                                  tile_done;
    logic [CNT_WIDTH-1:0]                  tile_len;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, a_bus, en_bus, tile_done, tile_len
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, a_bus, en_bus, tile_done, tile_len
    );
endinterface

// File: rtl/systolic_a_skew_feeder.sv
// Skews one activation vector per cycle onto the array rows (row r delayed r cycles),
// tracks tile boundaries and reports the completed tile once its last element reaches the bottom row.
module systolic_a_skew_feeder #(
    parameter int ROW_NUM          = 16,
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    systolic_a_skew_feeder_if.slave feed_if
);
    localparam int W   = INPUT_DATA_WIDTH;
    localparam int DCW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [DCW-1:0]       drain_cnt_q;
    logic [DCW-1:0]       drain_cnt_d;
    logic [CNT_WIDTH-1:0] vec_cnt_q;
    logic [CNT_WIDTH-1:0] vec_cnt_d;
    logic [CNT_WIDTH-1:0] vec_cnt_inc_s;
    logic [CNT_WIDTH-1:0] tile_len_q;
    logic [CNT_WIDTH-1:0] tile_len_d;
    logic                 ready_s;
    logic                 xfer_s;
    logic [ROW_NUM*W-1:0] a_bus_s;
    logic [ROW_NUM-1:0]   en_bus_s;

    // Acceptance is blocked only while the skew pipeline drains the finished tile.
    assign ready_s       = (state_q != ST_DRAIN);
    assign xfer_s        = feed_if.s_valid && ready_s;
    assign vec_cnt_inc_s = (vec_cnt_q == {CNT_WIDTH{1'b1}}) ? vec_cnt_q
                                                            : vec_cnt_q + CNT_WIDTH'(1);

    // Tile FSM, drain countdown and saturating per-tile vector counter.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        tile_len_d  = tile_len_q;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (xfer_s) begin
                    vec_cnt_d = vec_cnt_inc_s;
                    if (feed_if.s_last) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DCW'(ROW_NUM - 1);
                        tile_len_d  = vec_cnt_inc_s;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == {DCW{1'b0}}) begin
                    state_d   = ST_IDLE;
                    vec_cnt_d = {CNT_WIDTH{1'b0}};
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = {DCW{1'b0}};
                vec_cnt_d   = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= {DCW{1'b0}};
            vec_cnt_q   <= {CNT_WIDTH{1'b0}};
            tile_len_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            tile_len_q  <= tile_len_d;
        end
    end

    // Lane r holds r+1 stages; a non-transfer cycle injects a zero bubble so gaps keep the skew.
    for (genvar r = 0; r < ROW_NUM; r++) begin : g_lane
        logic [W-1:0] dat_q [0:r];
        logic [r:0]   en_q;

        // Shift this lane's data/enable chain every clock.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k <= r; k++) begin
                    dat_q[k] <= {W{1'b0}};
                end
                en_q <= {(r + 1){1'b0}};
            end else begin
                dat_q[0] <= xfer_s ? feed_if.s_data[r*W +: W] : {W{1'b0}};
                en_q[0]  <= xfer_s;
                for (int k = 1; k <= r; k++) begin
                    dat_q[k] <= dat_q[k-1];
                    en_q[k]  <= en_q[k-1];
                end
            end
        end

        assign a_bus_s[r*W +: W] = dat_q[r];
        assign en_bus_s[r]       = en_q[r];
    end

    assign feed_if.s_ready   = ready_s;
    assign feed_if.a_bus     = a_bus_s;
    assign feed_if.en_bus    = en_bus_s;
    assign feed_if.tile_len  = tile_len_q;
    assign feed_if.tile_done = (state_q == ST_DRAIN) && (drain_cnt_q == {DCW{1'b0}});

endmodule

// File: tb/tb_systolic_a_skew_feeder.sv
// Directed bench for the skew feeder: a history-of-transfers model predicts every row output,
// tile_done, tile_len and s_ready each cycle, and literal checks pin the model on key cycles.
module tb_systolic_a_skew_feeder;
    localparam int R    = 4;
    localparam int W    = 8;
    localparam int CW   = 3;
    localparam int SATV = (1 << CW) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    systolic_a_skew_feeder_if #(.ROW_NUM(R), .INPUT_DATA_WIDTH(W), .CNT_WIDTH(CW)) bus ();

    systolic_a_skew_feeder #(.ROW_NUM(R), .INPUT_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .feed_if (bus)
    );

    int n_pass     = 0;
    int n_total    = 0;
    int ecount     = 0;
    int valid_from = 1;
    int m_cnt      = 0;
    int m_len      = 0;

    // Per-edge record of what entered the array: data, whether it was a transfer, whether it closed a tile.
    logic [R*W-1:0] hist_d [0:1023];
    bit             hist_v [0:1023];
    bit             hist_l [0:1023];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    endtask

    function automatic bit slot_ok(input int m);
        return (m >= valid_from) && (m >= 1) && (m <= ecount);
    endfunction

    // Ready is low for the R cycles following an accepted last vector.
    function automatic bit m_ready();
        for (int k = 0; k < R; k++)
            if (slot_ok(ecount - k) && hist_l[ecount - k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare_all();
        logic [R*W-1:0] ea;
        logic [R-1:0]   ee;
        bit             etd;
        ea = '0;
        ee = '0;
        for (int r = 0; r < R; r++) begin
            int m;
            m = ecount - r;
            if (slot_ok(m)) begin
                ea[r*W +: W] = hist_d[m][r*W +: W];
                ee[r]        = hist_v[m];
            end
        end
        etd = slot_ok(ecount - (R - 1)) && hist_l[ecount - (R - 1)];
        chk("a_bus",     bus.a_bus,     ea);
        chk("en_bus",    bus.en_bus,    ee);
        chk("tile_done", bus.tile_done, etd);
        chk("tile_len",  bus.tile_len,  m_len);
        chk("s_ready",   bus.s_ready,   m_ready());
    endtask

    // One clock: drive at the falling edge, record model at the rising edge, compare at the next fall.
    task automatic cyc(input bit v, input logic [R*W-1:0] d, input bit l, output bit x);
        logic [R*W-1:0] junk;
        junk        = $urandom;
        bus.s_valid = v;
        bus.s_data  = v ? d : junk;
        bus.s_last  = l;
        x           = v && m_ready();
        @(posedge clk);
        ecount++;
        hist_v[ecount] = x;
        hist_l[ecount] = x && l;
        hist_d[ecount] = x ? d : '0;
        if (x) begin
            if (m_cnt < SATV) m_cnt++;
            if (l) begin
                m_len = m_cnt;
                m_cnt = 0;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [R*W-1:0] d, input bit l);
        bit x;
        x = 1'b0;
        for (int k = 0; k < 20 && !x; k++) cyc(1'b1, d, l, x);
        if (!x) begin
            n_total++;
            $display("FAIL send_timeout: vector %0h never accepted", d);
        end
    endtask

    task automatic idle(input int n);
        bit x;
        for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, x);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        chk("arst_a_bus",     bus.a_bus,     0);
        chk("arst_en_bus",    bus.en_bus,    0);
        chk("arst_tile_done", bus.tile_done, 0);
        chk("arst_tile_len",  bus.tile_len,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn       = 1'b1;
        valid_from = ecount + 1;
        m_cnt      = 0;
        m_len      = 0;
        chk("rst_ready", bus.s_ready, 1);
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit x;
        int e1;
        int e2;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
        repeat (2) @(negedge clk);
        chk("init_a_bus",    bus.a_bus,    0);
        chk("init_tile_len", bus.tile_len, 0);
        rstn = 1'b1;
        chk("init_ready", bus.s_ready, 1);
        compare_all();

        // Single-vector tile: diagonal wavefront.
        cyc(1'b1, 32'h04030201, 1'b1, x);
        chk("skew_a0", bus.a_bus, 32'h00000001);
        chk("skew_e0", bus.en_bus, 4'b0001);
        chk("skew_rdy0", bus.s_ready, 0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, x);
        chk("skew_a1", bus.a_bus, 32'h00000200);
        chk("skew_e1", bus.en_bus, 4'b0010);
        cyc(1'b0, '0, 1'b0, x);
        chk("skew_a2", bus.a_bus, 32'h00030000);
        chk("skew_e2", bus.en_bus, 4'b0100);
        cyc(1'b0, '0, 1'b0, x);
        chk("skew_a3", bus.a_bus, 32'h04000000);
        chk("skew_e3", bus.en_bus, 4'b1000);
        chk("skew_done", bus.tile_done, 1);
        chk("skew_len", bus.tile_len, 1);
        chk("skew_rdy3", bus.s_ready, 0);
        cyc(1'b0, '0, 1'b0, x);
        chk("skew_rdy4", bus.s_ready, 1);
        chk("skew_e4", bus.en_bus, 4'b0000);

        // Streaming with a gap.
        send(32'h44332211, 1'b0);
        send(32'h88776655, 1'b0);
        idle(1);
        send(32'hD4C3B2A1, 1'b1);
        idle(2);
        cyc(1'b0, '0, 1'b0, x);
        chk("gap_row3", bus.a_bus[31:24], 8'hD4);
        chk("gap_done", bus.tile_done, 1);
        chk("gap_len", bus.tile_len, 3);
        idle(2);

        // Back-to-back tiles with s_valid held high.
        send(32'h0A0B0C0D, 1'b0);
        send(32'h1A1B1C1D, 1'b1);
        e1 = ecount;
        chk("b2b_len1", bus.tile_len, 2);
        send(32'h2A2B2C2D, 1'b0);
        e2 = ecount;
        chk("b2b_gap", e2 - e1, R + 1);
        send(32'h3A3B3C3D, 1'b1);
        idle(R + 1);
        chk("b2b_len2", bus.tile_len, 2);

        // Signed extremes through every lane.
        send(32'h807F7F80, 1'b0);
        send(32'h7F80807F, 1'b1);
        idle(2);
        chk("sgn_rows", bus.a_bus[31:16], 16'h8080);
        cyc(1'b0, '0, 1'b0, x);
        chk("sgn_row3", bus.a_bus[31:24], 8'h7F);
        chk("sgn_done", bus.tile_done, 1);
        idle(2);

        // Ten-vector tile saturates the 3-bit counter.
        for (int i = 0; i < 9; i++) send(32'h01010101 * (i + 1), 1'b0);
        send(32'hF0E0D0C0, 1'b1);
        chk("sat_len", bus.tile_len, 7);
        idle(R + 1);

        // s_last with s_valid low is ignored.
        cyc(1'b0, '0, 1'b1, x);
        cyc(1'b0, '0, 1'b1, x);
        chk("lastnv_rdy", bus.s_ready, 1);
        chk("lastnv_len", bus.tile_len, 7);

        // Reset mid-tile discards in-flight elements.
        send(32'h55555555, 1'b0);
        send(32'h66666666, 1'b0);
        do_reset();
        idle(R + 3);
        send(32'h12345678, 1'b1);
        idle(R + 1);
        chk("post_rst_len", bus.tile_len, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
